fetch_ctrl: RTL

Sequencer for the instruction-fetch stage. Owns the PC register and drives a single-outstanding req/ack transaction to instruction memory. Presents fetched {pc, instr} to decode with a valid/ready handshake. Applies branch/jump redirects, squashing in-flight fetches, and flags misalignment or memory timeout.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_wdog.sv | 31 +++
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_DISCARD = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    // Size of one instruction word in bytes; sequential PC step.
    localparam int INSTR_BYTES = 4;

    // Default PC loaded on reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_wdog.sv
// Saturating wait counter for an outstanding memory request.
// timeout pulses in the cycle whose increment makes the count reach TIMEOUT,
// so the owner can move to its fault state on the following edge.
module fetch_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Count waiting cycles; clear wins, saturate at the top of the range.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign timeout = enable && !clear && (count >= LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs one outstanding req/ack
// access to instruction memory and presents {pc, instr} to decode.
//
// Handshakes: imem_req is a level held with imem_addr stable until a
// one-cycle imem_ack; decode takes the word in a cycle with
// if_valid & if_ready, and if_pc/if_instr stay stable while if_valid=1
// and if_ready=0. A redirect in HOLD wins over if_ready.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        fault,
    output logic [2:0]  debug_state
);

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pending_pc, pending_pc_n;
    logic [31:0] if_pc_n, if_instr_n;
    logic        wdog_clear, wdog_enable, timeout;
    logic        misaligned;

    assign imem_req    = (state == ST_REQ) || (state == ST_DISCARD);
    assign imem_addr   = pc;
    assign if_valid    = (state == ST_HOLD);
    assign fault       = (state == ST_FAULT);
    assign debug_state = state;

    assign misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Wait counter runs only while a request is outstanding and unanswered.
    assign wdog_enable = imem_req && !imem_ack;
    assign wdog_clear  = imem_ack || !imem_req;

    fetch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .nreset  (nreset),
        .clear   (wdog_clear),
        .enable  (wdog_enable),
        .timeout (timeout)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            pending_pc <= 32'd0;
            if_pc      <= 32'd0;
            if_instr   <= 32'd0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pending_pc <= pending_pc_n;
            if_pc      <= if_pc_n;
            if_instr   <= if_instr_n;
        end
    end

    // Next-state and datapath update; faults override normal sequencing.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pending_pc_n = pending_pc;
        if_pc_n      = if_pc;
        if_instr_n   = if_instr;

        case (state)
            ST_IDLE: begin
                state_n = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack && !redirect_valid) begin
                    if_instr_n = imem_rdata;
                    if_pc_n    = pc;
                    state_n    = ST_HOLD;
                end else if (imem_ack && redirect_valid) begin
                    // Word belongs to the squashed path; start over at target.
                    pc_n = redirect_pc;
                end else if (redirect_valid) begin
                    // Access still in flight: keep address until it completes.
                    pending_pc_n = redirect_pc;
                    state_n      = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (imem_ack) begin
                    pc_n    = redirect_valid ? redirect_pc : pending_pc;
                    state_n = ST_REQ;
                end else if (redirect_valid) begin
                    pending_pc_n = redirect_pc;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = ST_REQ;
                end else if (if_ready) begin
                    pc_n    = pc + 32'(INSTR_BYTES);
                    state_n = ST_REQ;
                end
            end
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
            default: begin
                state_n = ST_FAULT;
            end
        endcase

        if (state != ST_FAULT) begin
            if (misaligned) begin
                state_n      = ST_FAULT;
                pc_n         = pc;
                pending_pc_n = pending_pc;
                if_pc_n      = if_pc;
                if_instr_n   = if_instr;
            end else if (timeout) begin
                state_n = ST_FAULT;
            end
        end
    end

endmodule
